// File: rtl/regwr_arbiter_pkg.sv
// Shared defaults, requester ids and small helpers for the register-file
// write-back arbiter.
package regwr_pkg;

   localparam int unsigned DATA_W_DEF   = 64;
   localparam int unsigned ADDR_W_DEF   = 5;
   localparam int unsigned ZERO_REG_DEF = 31;
   localparam int unsigned WRCNT_W      = 16;

   // Requester ids: ALU write-back and load write-back.
   typedef enum logic {
      REQ_ALU  = 1'b0,
      REQ_LOAD = 1'b1
   } req_id_e;

   // The id that receives priority after a transfer from the given one.
   function automatic req_id_e other_id(input req_id_e id);
      return (id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
   endfunction

endpackage

// File: rtl/regwr_arbiter_if.sv
// Requester handshake and register-file write bus of the write-back arbiter.
interface regwr_arbiter_if
   import regwr_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);
   logic               Hold;
   logic               V0;
   logic [ADDR_W-1:0]  RW0;
   logic [DATA_W-1:0]  BusW0;
   logic               Rdy0;
   logic               V1;
   logic [ADDR_W-1:0]  RW1;
   logic [DATA_W-1:0]  BusW1;
   logic               Rdy1;
   logic               RegWr;
   logic [ADDR_W-1:0]  RW;
   logic [DATA_W-1:0]  BusW;
   logic               GntId;
   logic [WRCNT_W-1:0] WrCount;

   // Requester / environment side.
   modport master (
      output Hold, V0, RW0, BusW0, V1, RW1, BusW1,
      input  Rdy0, Rdy1, RegWr, RW, BusW, GntId, WrCount
   );

   // Arbiter side.
   modport slave (
      input  Hold, V0, RW0, BusW0, V1, RW1, BusW1,
      output Rdy0, Rdy1, RegWr, RW, BusW, GntId, WrCount
   );
endinterface

// File: rtl/regwr_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority pointer. Grants are
// combinational and suppressed while hold or reset is asserted.
module rr_arb2
   import regwr_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic hold,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   req_id_e prio_q;
   req_id_e prio_d;

   // Grant selection: a lone requester wins, a conflict goes to the pointer.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && !hold) begin
         if (req0 && req1) begin
            gnt0 = (prio_q == REQ_ALU);
            gnt1 = (prio_q == REQ_LOAD);
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Pointer moves to the other requester after any grant, holds otherwise.
   always_comb begin
      prio_d = prio_q;
      if (gnt0) begin
         prio_d = other_id(REQ_ALU);
      end else if (gnt1) begin
         prio_d = other_id(REQ_LOAD);
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prio_q <= REQ_ALU;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/regwr_arbiter.sv
// Register-file write-back arbiter: merges ALU and load write-back streams
// into one registered write port; writes to the zero register are accepted
// and discarded.
module regwr_arbiter
   import regwr_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned ZERO_REG = ZERO_REG_DEF
)(
   input  logic           Clk,
   input  logic           Reset,
   regwr_arbiter_if.slave bus
);

   logic               gnt0;
   logic               gnt1;
   logic               xfer;
   logic [ADDR_W-1:0]  sel_rw;
   logic [DATA_W-1:0]  sel_busw;

   logic               regwr_q,    regwr_d;
   logic [ADDR_W-1:0]  rw_q,       rw_d;
   logic [DATA_W-1:0]  busw_q,     busw_d;
   logic               gnt_id_q,   gnt_id_d;
   logic [WRCNT_W-1:0] wr_count_q, wr_count_d;

   rr_arb2 u_arb (
      .clk  (Clk),
      .rst  (Reset),
      .hold (bus.Hold),
      .req0 (bus.V0),
      .req1 (bus.V1),
      .gnt0 (gnt0),
      .gnt1 (gnt1)
   );

   // Next-state of the write port from the winning requester.
   always_comb begin
      xfer       = gnt0 | gnt1;
      sel_rw     = gnt1 ? bus.RW1   : bus.RW0;
      sel_busw   = gnt1 ? bus.BusW1 : bus.BusW0;
      regwr_d    = xfer && (sel_rw != ADDR_W'(ZERO_REG));
      rw_d       = regwr_d ? sel_rw   : rw_q;
      busw_d     = regwr_d ? sel_busw : busw_q;
      gnt_id_d   = xfer ? gnt1 : gnt_id_q;
      // Count moves together with RegWr so it already includes the write on the port.
      wr_count_d = wr_count_q + WRCNT_W'(regwr_d);
   end

   // Output registers; reset also discards a write accepted but not yet driven.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         regwr_q    <= 1'b0;
         rw_q       <= '0;
         busw_q     <= '0;
         gnt_id_q   <= 1'b0;
         wr_count_q <= '0;
      end else begin
         regwr_q    <= regwr_d;
         rw_q       <= rw_d;
         busw_q     <= busw_d;
         gnt_id_q   <= gnt_id_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign bus.Rdy0    = gnt0;
   assign bus.Rdy1    = gnt1;
   assign bus.RegWr   = regwr_q;
   assign bus.RW      = rw_q;
   assign bus.BusW    = busw_q;
   assign bus.GntId   = gnt_id_q;
   assign bus.WrCount = wr_count_q;

endmodule
